study_judge: RTL and testbench

//  Scores the player in study mode. Takes each struck note (octave/note/length plus a strobe from the
//  key-hit stage) and compares it against the goal note of the selected song track. Drives the song

---
 rtl/study_judge_pkg.sv | 68 ++++++
 rtl/study_judge_timer.sv | 55 +++++
 rtl/study_judge.sv | 178 +++++++++++++++++
 tb/tb_study_judge.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/study_judge_pkg.sv
// Shared types and constants for the study-mode judge.
// Field widths, grade codes, FSM states and saturating helpers.
package study_judge_pkg;

  localparam int OCT_W      = 2;
  localparam int NOTE_W     = 3;
  localparam int LEN_W      = 3;
  localparam int SCORE_W    = 10;
  localparam int STREAK_W   = 7;
  localparam int SCORE_MAX  = 999;
  localparam int STREAK_MAX = 99;

  localparam logic [NOTE_W-1:0] NOTE_REST = '0;

  typedef enum logic [1:0] {
    GR_NONE    = 2'd0,
    GR_MISS    = 2'd1,
    GR_GOOD    = 2'd2,
    GR_PERFECT = 2'd3
  } grade_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [OCT_W-1:0]  octave;
    logic [NOTE_W-1:0] note;
    logic [LEN_W-1:0]  length;
  } note_t;

  function automatic int ms_ticks(input int clk_hz);
    return (clk_hz / 1000 > 0) ? clk_hz / 1000 : 1;
  endfunction

  function automatic grade_e judge(input note_t goal,
                                   input note_t play);
    if (goal == play)
      return GR_PERFECT;
    if (goal.octave == play.octave && goal.note == play.note)
      return GR_GOOD;
    return GR_MISS;
  endfunction

  function automatic logic [SCORE_W-1:0] score_add(
    input logic [SCORE_W-1:0] s,
    input logic [1:0]         inc
  );
    logic [SCORE_W:0] t;
    t = {1'b0, s} + (SCORE_W+1)'(inc);
    if (t > (SCORE_W+1)'(SCORE_MAX))
      return SCORE_W'(SCORE_MAX);
    return t[SCORE_W-1:0];
  endfunction

  function automatic logic [STREAK_W-1:0] streak_inc(
    input logic [STREAK_W-1:0] s
  );
    if (s >= STREAK_W'(STREAK_MAX))
      return STREAK_W'(STREAK_MAX);
    return s + STREAK_W'(1);
  endfunction

endpackage

// File: rtl/study_judge_timer.sv
// Per-goal timeout: millisecond prescaler feeding a ms counter.
// expired pulses for one cycle when TIMEOUT_MS ms have run out.
module judge_timer #(
  parameter int MS_TICKS   = 100000,
  parameter int TIMEOUT_MS = 3000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic expired
);

  localparam int PW = $clog2(MS_TICKS + 1);
  localparam int MW = $clog2(TIMEOUT_MS + 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [MW-1:0] ms_q, ms_d;
  logic          tick;

  assign tick = (pre_q == PW'(MS_TICKS - 1));

  always_comb begin
    pre_d   = pre_q;
    ms_d    = ms_q;
    expired = 1'b0;
    if (restart) begin
      pre_d = '0;
      ms_d  = '0;
    end else if (run) begin
      if (tick) begin
        pre_d = '0;
        if (ms_q == MW'(TIMEOUT_MS - 1)) begin
          expired = 1'b1;
          ms_d    = '0;
        end else begin
          ms_d = ms_q + MW'(1);
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else begin
      pre_q <= pre_d;
      ms_q  <= ms_d;
    end
  end

endmodule

// File: rtl/study_judge.sv
// Study-mode judge: grades struck notes against the song track,
// steps the song index and keeps score and streak for the display.
module study_judge
  import study_judge_pkg::*;
#(
  parameter int CNT_W      = 6,
  parameter int CLK_HZ     = 100_000_000,
  parameter int TIMEOUT_MS = 3000,
  parameter int RETRY_MAX  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                start,
  input  logic [CNT_W-1:0]    track_len,
  input  logic [OCT_W-1:0]    goal_octave,
  input  logic [NOTE_W-1:0]   goal_note,
  input  logic [LEN_W-1:0]    goal_length,
  input  logic                play_valid,
  input  logic [OCT_W-1:0]    play_octave,
  input  logic [NOTE_W-1:0]   play_note,
  input  logic [LEN_W-1:0]    play_length,
  output logic [CNT_W-1:0]    note_idx,
  output logic                advance,
  output logic [1:0]          grade,
  output logic [SCORE_W-1:0]  score,
  output logic [STREAK_W-1:0] streak,
  output logic                busy,
  output logic                done
);

  localparam int RW       = $clog2(RETRY_MAX + 1);
  localparam int MS_TICKS = ms_ticks(CLK_HZ);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     idx_q, idx_d, idx_inc;
  note_t                goal_q, goal_d, play;
  logic [RW-1:0]        retry_q, retry_d, retry_inc;
  grade_e               grade_q, grade_d, verdict;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [STREAK_W-1:0]  streak_q, streak_d;
  logic                 adv_q, adv_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tmr_restart, tmr_run, expired;

  assign play    = '{play_octave, play_note, play_length};
  assign verdict = judge(goal_q, play);

  // The timer only runs in WAIT; any strike restarts it, so a strike
  // on the expiry edge always beats the timeout.
  assign tmr_run     = (state_q == S_WAIT);
  assign tmr_restart = !en || start || !tmr_run || play_valid;

  judge_timer #(
    .MS_TICKS   (MS_TICKS),
    .TIMEOUT_MS (TIMEOUT_MS)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (tmr_restart),
    .run     (tmr_run),
    .expired (expired)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    goal_d    = goal_q;
    retry_d   = retry_q;
    grade_d   = grade_q;
    score_d   = score_q;
    streak_d  = streak_q;
    idx_inc   = idx_q + CNT_W'(1);
    retry_inc = retry_q + RW'(1);

    if (!en) begin
      state_d  = S_IDLE;
      idx_d    = '0;
      goal_d   = '0;
      retry_d  = '0;
      grade_d  = GR_NONE;
      score_d  = '0;
      streak_d = '0;
    end else if (start) begin
      state_d  = (track_len == '0) ? S_DONE : S_LOAD;
      idx_d    = '0;
      retry_d  = '0;
      grade_d  = GR_NONE;
      score_d  = '0;
      streak_d = '0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          goal_d  = '{goal_octave, goal_note, goal_length};
          retry_d = '0;
          state_d = (goal_note == NOTE_REST) ? S_NEXT : S_WAIT;
        end
        S_WAIT: begin
          if (play_valid) begin
            grade_d = verdict;
            case (verdict)
              GR_PERFECT: begin
                score_d  = score_add(score_q, 2'd3);
                streak_d = streak_inc(streak_q);
                state_d  = S_NEXT;
              end
              GR_GOOD: begin
                score_d  = score_add(score_q, 2'd1);
                streak_d = streak_inc(streak_q);
                state_d  = S_NEXT;
              end
              default: begin
                streak_d = '0;
                retry_d  = retry_inc;
                if (retry_inc == RW'(RETRY_MAX))
                  state_d = S_NEXT;
              end
            endcase
          end else if (expired) begin
            grade_d  = GR_MISS;
            streak_d = '0;
            state_d  = S_NEXT;
          end
        end
        S_NEXT: begin
          if (idx_inc == track_len) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_inc;
            state_d = S_LOAD;
          end
        end
        default: ;
      endcase
    end

    adv_d  = (state_d == S_NEXT);
    busy_d = (state_d == S_LOAD) || (state_d == S_WAIT) ||
             (state_d == S_NEXT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      goal_q   <= '0;
      retry_q  <= '0;
      grade_q  <= GR_NONE;
      score_q  <= '0;
      streak_q <= '0;
      adv_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      goal_q   <= goal_d;
      retry_q  <= retry_d;
      grade_q  <= grade_d;
      score_q  <= score_d;
      streak_q <= streak_d;
      adv_q    <= adv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign note_idx = idx_q;
  assign advance  = adv_q;
  assign grade    = grade_q;
  assign score    = score_q;
  assign streak   = streak_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_study_judge.sv
// Bench for study_judge: directed scenarios plus random songs,
// checked against a note-level reference model.
module tb_study_judge;

  localparam int CNT_W = 9;
  localparam int TMO   = 25;
  localparam int RMAX  = 3;

  localparam int M_LOAD = 0;
  localparam int M_WAIT = 1;
  localparam int M_DONE = 2;
  localparam int M_IDLE = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] track_len = '0;
  logic [1:0]       goal_octave;
  logic [2:0]       goal_note;
  logic [2:0]       goal_length;
  logic             play_valid = 1'b0;
  logic [1:0]       play_octave = '0;
  logic [2:0]       play_note = '0;
  logic [2:0]       play_length = '0;
  logic [CNT_W-1:0] note_idx;
  logic             advance;
  logic [1:0]       grade;
  logic [9:0]       score;
  logic [6:0]       streak;
  logic             busy;
  logic             done;

  logic [7:0] rom [512];

  int checks = 0;
  int errors = 0;
  int adv_cnt = 0;
  int m_score, m_streak, m_grade, m_idx, m_len;
  int m_retry, m_elapsed, m_st, m_adv;

  study_judge #(
    .CNT_W      (CNT_W),
    .CLK_HZ     (1000),
    .TIMEOUT_MS (TMO),
    .RETRY_MAX  (RMAX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .start       (start),
    .track_len   (track_len),
    .goal_octave (goal_octave),
    .goal_note   (goal_note),
    .goal_length (goal_length),
    .play_valid  (play_valid),
    .play_octave (play_octave),
    .play_note   (play_note),
    .play_length (play_length),
    .note_idx    (note_idx),
    .advance     (advance),
    .grade       (grade),
    .score       (score),
    .streak      (streak),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  assign {goal_octave, goal_note, goal_length} = rom[note_idx];

  always @(posedge clk)
    if (advance === 1'b1)
      adv_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int judge(input logic [7:0] g, input logic [7:0] p);
    if (g == p) return 3;
    if (g[7:3] == p[7:3]) return 2;
    return 1;
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".grade"}, 32'(grade), m_grade);
    chk({tag, ".score"}, 32'(score), m_score);
    chk({tag, ".streak"}, 32'(streak), m_streak);
  endtask

  task automatic model_clear();
    m_score = 0; m_streak = 0; m_grade = 0;
    m_idx = 0; m_retry = 0; m_elapsed = 0;
  endtask

  // DUT sits on a NEXT cycle
  task automatic after_next();
    chk("advance_hi", 32'(advance), 1);
    check_outs("next");
    m_adv++;
    step();
    if (m_idx + 1 == m_len) begin
      m_st = M_DONE;
      chk("done_hi", 32'(done), 1);
      chk("busy_done", 32'(busy), 0);
      chk("idx_hold", 32'(note_idx), m_idx);
    end else begin
      m_idx++;
      m_st = M_LOAD;
      chk("idx_step", 32'(note_idx), m_idx);
      chk("advance_lo", 32'(advance), 0);
    end
  endtask

  task automatic load_to_wait();
    while (m_st == M_LOAD) begin
      step();
      m_retry = 0;
      m_elapsed = 0;
      if (rom[m_idx][5:3] == 3'd0) begin
        after_next();
      end else begin
        m_st = M_WAIT;
        chk("busy_wait", 32'(busy), 1);
      end
    end
  endtask

  task automatic do_start(input int len);
    track_len = CNT_W'(len);
    m_len = len;
    start = 1'b1;
    step();
    start = 1'b0;
    model_clear();
    m_st = (len == 0) ? M_DONE : M_LOAD;
    chk("start_idx", 32'(note_idx), 0);
    chk("start_done", 32'(done), (len == 0) ? 1 : 0);
    chk("start_busy", 32'(busy), (len == 0) ? 0 : 1);
    check_outs("start");
  endtask

  task automatic strike(input logic [7:0] p);
    int g;
    bit leave;
    {play_octave, play_note, play_length} = p;
    play_valid = 1'b1;
    step();
    play_valid = 1'b0;
    g = judge(rom[m_idx], p);
    m_grade = g;
    leave = 1'b1;
    if (g == 3) begin
      m_score = (m_score + 3 > 999) ? 999 : m_score + 3;
      m_streak = (m_streak + 1 > 99) ? 99 : m_streak + 1;
    end else if (g == 2) begin
      m_score = (m_score + 1 > 999) ? 999 : m_score + 1;
      m_streak = (m_streak + 1 > 99) ? 99 : m_streak + 1;
    end else begin
      m_streak = 0;
      m_retry++;
      leave = (m_retry == RMAX);
      m_elapsed = 0;
    end
    if (leave) begin
      after_next();
      load_to_wait();
    end else begin
      check_outs("retry");
      chk("advance_retry", 32'(advance), 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      m_elapsed++;
      if (m_elapsed == TMO) begin
        m_grade = 1;
        m_streak = 0;
        after_next();
        load_to_wait();
        break;
      end
      chk("advance_idle", 32'(advance), 0);
    end
  endtask

  task automatic stray(input logic [7:0] p);
    {play_octave, play_note, play_length} = p;
    play_valid = 1'b1;
    step();
    play_valid = 1'b0;
    check_outs("stray");
  endtask

  initial begin
    int base;
    int guard;
    int act;
    logic [7:0] p;
    logic [7:0] g;

    for (int i = 0; i < 512; i++) rom[i] = 8'h49;
    model_clear();
    m_adv = 0;
    m_st = M_IDLE;

    // reset state
    repeat (2) step();
    check_outs("reset");
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_idx", 32'(note_idx), 0);
    rst_n = 1'b1;
    en = 1'b1;
    step();

    // three exact strikes
    rom[0] = {2'd1, 3'd3, 3'd2};
    rom[1] = {2'd2, 3'd5, 3'd1};
    rom[2] = {2'd0, 3'd7, 3'd7};
    base = adv_cnt;
    do_start(3);
    load_to_wait();
    for (int i = 0; i < 3; i++) strike(rom[i]);
    chk("t1_score", 32'(score), 9);
    chk("t1_streak", 32'(streak), 3);
    chk("t1_grade", 32'(grade), 3);
    chk("t1_adv", adv_cnt - base, 3);
    stray(8'h5a);
    chk("stray_done", 32'(done), 1);

    // good, then three wrong strikes
    rom[0] = {2'd1, 3'd3, 3'd2};
    rom[1] = {2'd3, 3'd1, 3'd1};
    do_start(2);
    load_to_wait();
    strike({2'd1, 3'd3, 3'd4});
    chk("t2_good", 32'(grade), 2);
    for (int i = 0; i < 3; i++) strike({2'd0, 3'd2, 3'd1});
    chk("t2_miss", 32'(grade), 1);
    chk("t2_streak", 32'(streak), 0);
    chk("t2_done", 32'(done), 1);

    // timeout, then strike on the expiry edge
    do_start(2);
    load_to_wait();
    idle(TMO);
    chk("t3_tmo", 32'(grade), 1);
    idle(TMO - 1);
    strike(rom[1]);
    chk("t3_edge", 32'(grade), 3);

    // rest goal, then empty track
    rom[0] = 8'h00;
    rom[1] = {2'd2, 3'd4, 3'd3};
    do_start(2);
    load_to_wait();
    chk("t4_rest_idx", 32'(note_idx), 1);
    check_outs("t4_rest");
    strike(rom[1]);
    do_start(0);

    // saturation of score and streak
    for (int i = 0; i < 340; i++) rom[i] = {2'd1, 3'd1, 3'd1};
    do_start(340);
    load_to_wait();
    for (int i = 0; i < 340; i++) begin
      p = rom[i];
      if (i == 332 || i == 333) p[2:0] = 3'd5;
      strike(p);
    end
    chk("sat_score", 32'(score), 999);
    chk("sat_streak", 32'(streak), 99);

    // mid-song start, reset and disable
    rom[0] = 8'h49; rom[1] = 8'h51; rom[2] = 8'h62;
    do_start(3);
    load_to_wait();
    strike(rom[0]);
    do_start(3);
    load_to_wait();
    strike(rom[1]);
    rst_n = 1'b0;
    #1;
    model_clear();
    m_st = M_IDLE;
    check_outs("mid_rst");
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_idx", 32'(note_idx), 0);
    step();
    rst_n = 1'b1;
    do_start(3);
    load_to_wait();
    strike(rom[0]);
    en = 1'b0;
    step();
    model_clear();
    m_st = M_IDLE;
    check_outs("en_low");
    chk("en_low_busy", 32'(busy), 0);
    chk("en_low_idx", 32'(note_idx), 0);
    en = 1'b1;
    step();

    // random songs
    for (int s = 0; s < 8; s++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        g = 8'($urandom);
        if ($urandom_range(0, 4) == 0) g[5:3] = 3'd0;
        rom[i] = g;
      end
      base = adv_cnt;
      m_adv = 0;
      do_start(len);
      load_to_wait();
      guard = 0;
      while (m_st == M_WAIT && guard < 300) begin
        guard++;
        act = $urandom_range(0, 9);
        g = rom[m_idx];
        if (act < 3) begin
          strike(g);
        end else if (act < 5) begin
          p = g;
          p[2:0] = p[2:0] + 3'($urandom_range(1, 7));
          strike(p);
        end else if (act < 8) begin
          strike(8'($urandom));
        end else begin
          idle($urandom_range(1, TMO + 2));
        end
      end
      chk("rand_guard", 32'(guard < 300), 1);
      chk("rand_done", 32'(done), 1);
      check_outs("rand_end");
      step();
      chk("rand_adv", adv_cnt - base, m_adv);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
